// File: rtl/dpi_stream_feeder_if.sv
// Ingress handshake bundle for dpi_stream_feeder.
//   s_key / s_key_vld / s_key_rdy                 : one flow key per packet
//   s_data / s_data_vld / s_data_last / s_data_rdy : payload bytes, last marks end
// master = packet source, slave = feeder.
interface dpi_stream_feeder_if #(
    parameter int KEY_W = 32
) ();
    logic [KEY_W-1:0] s_key;
    logic             s_key_vld;
    logic             s_key_rdy;
    logic [7:0]       s_data;
    logic             s_data_vld;
    logic             s_data_last;
    logic             s_data_rdy;

    modport master (
        output s_key, s_key_vld, s_data, s_data_vld, s_data_last,
        input  s_key_rdy, s_data_rdy
    );

    modport slave (
        input  s_key, s_key_vld, s_data, s_data_vld, s_data_last,
        output s_key_rdy, s_data_rdy
    );
endinterface

// File: rtl/dpi_stream_feeder.sv
// dpi_stream_feeder: per-packet sequencer for the DPI matcher bank.
// Maps each packet's flow key to a 6-bit stream id via a 64-entry fully
// associative flow table (round-robin allocation/eviction), then emits the
// load_state -> gap -> char stream -> drain -> eop sequence for the matchers.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   ing (slave)         : key and payload handshakes
//   cfg_en_*            : per-stream enable table write port
//   load_state, stream_id, new_stream_id, enable : per-packet matcher control
//   char_in, char_in_vld, eop                    : character stream and commit
//   pkt_count, miss_count                        : wrapping statistics
// All outputs are registered.
module dpi_stream_feeder #(
    parameter int KEY_W    = 32,
    parameter int LOAD_GAP = 2,
    parameter int DRAIN    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dpi_stream_feeder_if.slave   ing,
    input  logic                 cfg_en_we,
    input  logic [5:0]           cfg_en_addr,
    input  logic                 cfg_en_data,
    output logic                 load_state,
    output logic [5:0]           stream_id,
    output logic                 new_stream_id,
    output logic                 enable,
    output logic [7:0]           char_in,
    output logic                 char_in_vld,
    output logic                 eop,
    output logic [15:0]          pkt_count,
    output logic [15:0]          miss_count
);

    localparam int NUM_FLOWS = 64;
    localparam logic [7:0] GAP_LAST   = 8'(LOAD_GAP - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_LOAD, S_GAP, S_STREAM, S_DRAIN, S_EOP
    } state_e;

    state_e                 state_q, state_d;
    logic [KEY_W-1:0]       key_q, key_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [5:0]             sid_q, sid_d;
    logic                   new_q, new_d;
    logic                   enable_q, enable_d;
    logic                   load_state_q, load_state_d;
    logic                   s_key_rdy_q, s_key_rdy_d;
    logic                   s_data_rdy_q, s_data_rdy_d;
    logic [7:0]             char_in_q, char_in_d;
    logic                   char_in_vld_q, char_in_vld_d;
    logic                   eop_q, eop_d;
    logic [15:0]            pkt_count_q, pkt_count_d;
    logic [15:0]            miss_count_q, miss_count_d;
    logic [5:0]             alloc_ptr_q, alloc_ptr_d;
    logic [NUM_FLOWS-1:0]   tbl_vld_q, tbl_vld_d;
    logic [NUM_FLOWS-1:0]   en_tbl_q, en_tbl_d;

    // Key storage needs no reset: an entry is only meaningful with its valid bit.
    logic [KEY_W-1:0]       key_tbl_q [NUM_FLOWS];
    logic                   tbl_we;

    logic                   hit;
    logic [5:0]             hit_idx;

    // Associative match of the latched key against every valid entry.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            if (!hit && tbl_vld_q[i] && key_tbl_q[i] == key_q) begin
                hit     = 1'b1;
                hit_idx = i[5:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        cnt_d         = cnt_q;
        sid_d         = sid_q;
        new_d         = new_q;
        enable_d      = enable_q;
        load_state_d  = 1'b0;
        s_key_rdy_d   = s_key_rdy_q;
        s_data_rdy_d  = s_data_rdy_q;
        char_in_d     = char_in_q;
        char_in_vld_d = 1'b0;
        eop_d         = 1'b0;
        pkt_count_d   = pkt_count_q;
        miss_count_d  = miss_count_q;
        alloc_ptr_d   = alloc_ptr_q;
        tbl_vld_d     = tbl_vld_q;
        tbl_we        = 1'b0;

        // Config writes land immediately; the LOOKUP read below sees them too.
        en_tbl_d = en_tbl_q;
        if (cfg_en_we) en_tbl_d[cfg_en_addr] = cfg_en_data;

        case (state_q)
            S_IDLE: begin
                s_key_rdy_d = 1'b1;
                if (ing.s_key_vld && s_key_rdy_q) begin
                    key_d       = ing.s_key;
                    s_key_rdy_d = 1'b0;
                    state_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    sid_d = hit_idx;
                    new_d = 1'b0;
                end else begin
                    // Miss: claim the round-robin slot, evicting whatever is there.
                    sid_d                  = alloc_ptr_q;
                    new_d                  = 1'b1;
                    tbl_we                 = 1'b1;
                    tbl_vld_d[alloc_ptr_q] = 1'b1;
                    alloc_ptr_d            = alloc_ptr_q + 6'd1;
                    miss_count_d           = miss_count_q + 16'd1;
                end
                enable_d     = en_tbl_d[sid_d];
                load_state_d = 1'b1;
                cnt_d        = '0;
                state_d      = S_LOAD;
            end
            S_LOAD, S_GAP: begin
                // Counted from the load_state cycle so the first byte is
                // accepted exactly LOAD_GAP cycles after it.
                if (cnt_q == GAP_LAST) begin
                    s_data_rdy_d = 1'b1;
                    state_d      = S_STREAM;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = S_GAP;
                end
            end
            S_STREAM: begin
                if (ing.s_data_vld && s_data_rdy_q) begin
                    char_in_d     = ing.s_data;
                    char_in_vld_d = 1'b1;
                    if (ing.s_data_last) begin
                        s_data_rdy_d = 1'b0;
                        cnt_d        = '0;
                        state_d      = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // First DRAIN cycle carries the last char_in_vld.
                if (cnt_q == DRAIN_LAST) begin
                    eop_d       = 1'b1;
                    pkt_count_d = pkt_count_q + 16'd1;
                    state_d     = S_EOP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EOP: begin
                s_key_rdy_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            key_q         <= '0;
            cnt_q         <= '0;
            sid_q         <= '0;
            new_q         <= 1'b0;
            enable_q      <= 1'b0;
            load_state_q  <= 1'b0;
            s_key_rdy_q   <= 1'b0;
            s_data_rdy_q  <= 1'b0;
            char_in_q     <= '0;
            char_in_vld_q <= 1'b0;
            eop_q         <= 1'b0;
            pkt_count_q   <= '0;
            miss_count_q  <= '0;
            alloc_ptr_q   <= '0;
            tbl_vld_q     <= '0;
            en_tbl_q      <= '1;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            cnt_q         <= cnt_d;
            sid_q         <= sid_d;
            new_q         <= new_d;
            enable_q      <= enable_d;
            load_state_q  <= load_state_d;
            s_key_rdy_q   <= s_key_rdy_d;
            s_data_rdy_q  <= s_data_rdy_d;
            char_in_q     <= char_in_d;
            char_in_vld_q <= char_in_vld_d;
            eop_q         <= eop_d;
            pkt_count_q   <= pkt_count_d;
            miss_count_q  <= miss_count_d;
            alloc_ptr_q   <= alloc_ptr_d;
            tbl_vld_q     <= tbl_vld_d;
            en_tbl_q      <= en_tbl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) key_tbl_q[alloc_ptr_q] <= key_q;
    end

    assign ing.s_key_rdy  = s_key_rdy_q;
    assign ing.s_data_rdy = s_data_rdy_q;
    assign load_state     = load_state_q;
    assign stream_id      = sid_q;
    assign new_stream_id  = new_q;
    assign enable         = enable_q;
    assign char_in        = char_in_q;
    assign char_in_vld    = char_in_vld_q;
    assign eop            = eop_q;
    assign pkt_count      = pkt_count_q;
    assign miss_count     = miss_count_q;

endmodule

// File: tb/tb_dpi_stream_feeder.sv
module tb_dpi_stream_feeder;
    localparam int KEY_W    = 32;
    localparam int LOAD_GAP = 2;
    localparam int DRAIN    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dpi_stream_feeder_if #(.KEY_W(KEY_W)) ing ();

    logic        cfg_en_we;
    logic [5:0]  cfg_en_addr;
    logic        cfg_en_data;
    logic        load_state, new_stream_id, enable, char_in_vld, eop;
    logic [5:0]  stream_id;
    logic [7:0]  char_in;
    logic [15:0] pkt_count, miss_count;

    dpi_stream_feeder #(.KEY_W(KEY_W), .LOAD_GAP(LOAD_GAP), .DRAIN(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .ing(ing),
        .cfg_en_we(cfg_en_we), .cfg_en_addr(cfg_en_addr), .cfg_en_data(cfg_en_data),
        .load_state(load_state), .stream_id(stream_id), .new_stream_id(new_stream_id),
        .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
        .pkt_count(pkt_count), .miss_count(miss_count)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard of bytes accepted by the DUT, in order.
    logic [7:0] exp_chr_q[$];
    int         exp_pkt, exp_miss;

    // Monitor: per-packet observations, and char/hold scoreboard checks.
    int          ld_cyc, eop_cyc, first_chr, last_chr, n_eop = 0;
    int          chr_cyc[$];
    logic [5:0]  ld_sid;
    logic        ld_new, ld_en, in_pkt = 1'b0;
    logic [15:0] eop_pkt, eop_miss;
    logic [7:0]  e_chr;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_pkt = 1'b0;
        end else begin
            if (in_pkt) begin
                n_cmp++;
                if ({stream_id, new_stream_id, enable} !== {ld_sid, ld_new, ld_en}) begin
                    n_fail++;
                    $display("FAIL hold cyc=%0d got sid=%0d new=%0b en=%0b want sid=%0d new=%0b en=%0b",
                             cyc, stream_id, new_stream_id, enable, ld_sid, ld_new, ld_en);
                end
            end
            if (load_state) begin
                ld_cyc = cyc; ld_sid = stream_id; ld_new = new_stream_id; ld_en = enable;
                first_chr = -1; chr_cyc = {}; in_pkt = 1'b1;
            end
            if (char_in_vld) begin
                if (first_chr < 0) first_chr = cyc;
                last_chr = cyc;
                chr_cyc.push_back(cyc);
                n_cmp++;
                if (exp_chr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL chr_extra cyc=%0d got %02h want none", cyc, char_in);
                end else begin
                    e_chr = exp_chr_q.pop_front();
                    if (char_in !== e_chr) begin
                        n_fail++;
                        $display("FAIL chr cyc=%0d got %02h want %02h", cyc, char_in, e_chr);
                    end
                end
            end
            if (eop) begin
                eop_cyc = cyc; eop_pkt = pkt_count; eop_miss = miss_count;
                n_eop++; in_pkt = 1'b0;
            end
        end
    end

    // Drives one packet; returns the key-handshake cycle. Entered and left at posedge+1.
    task automatic run_pkt(input logic [31:0] key, input logic [7:0] bytes[$],
                           input int bubble_after, input int cfg_at, output int t0);
        int n, e0;
        e0 = n_eop;
        ing.s_key = key; ing.s_key_vld = 1'b1;
        for (n = 0; n < 50; n++) begin @(negedge clk); if (ing.s_key_rdy) break; end
        if (n == 50) begin
            n_cmp++; n_fail++;
            $display("FAIL key_timeout got rdy=0 want rdy=1 key=%08h", key);
            ing.s_key_vld = 1'b0; t0 = cyc; return;
        end
        t0 = cyc;
        @(posedge clk); #1 ing.s_key_vld = 1'b0;
        for (int b = 0; b < bytes.size(); b++) begin
            ing.s_data = bytes[b]; ing.s_data_vld = 1'b1;
            ing.s_data_last = (b == bytes.size() - 1);
            if (cfg_at == b) begin cfg_en_we = 1'b1; cfg_en_addr = 6'd0; cfg_en_data = 1'b0; end
            for (n = 0; n < 50; n++) begin @(negedge clk); if (ing.s_data_rdy) break; end
            if (n == 50) begin
                n_cmp++; n_fail++;
                $display("FAIL data_timeout got rdy=0 want rdy=1 byte=%0d", b);
                ing.s_data_vld = 1'b0; cfg_en_we = 1'b0; return;
            end
            exp_chr_q.push_back(bytes[b]);
            @(posedge clk); #1 ing.s_data_vld = 1'b0; ing.s_data_last = 1'b0; cfg_en_we = 1'b0;
            if (bubble_after == b) begin @(posedge clk); #1; end
        end
        for (n = 0; n < 50 && n_eop == e0; n++) @(posedge clk);
        if (n_eop == e0) begin
            n_cmp++; n_fail++;
            $display("FAIL eop_timeout got no eop want eop key=%08h", key);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        exp_chr_q = {}; exp_pkt = 0; exp_miss = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        ing.s_key = '0; ing.s_key_vld = 1'b0; ing.s_data = '0;
        ing.s_data_vld = 1'b0; ing.s_data_last = 1'b0;
        cfg_en_we = 1'b0; cfg_en_addr = '0; cfg_en_data = 1'b0;
        exp_pkt = 0; exp_miss = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({load_state, stream_id, new_stream_id, enable, char_in, char_in_vld, eop} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 0",
                     {load_state, stream_id, new_stream_id, enable, char_in, char_in_vld, eop});
        end
        n_cmp++;
        if ({pkt_count, miss_count} !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", pkt_count, miss_count);
        end
        n_cmp++;
        if ({ing.s_key_rdy, ing.s_data_rdy} !== 2'b00) begin
            n_fail++; $display("FAIL reset_rdy got %b want 00", {ing.s_key_rdy, ing.s_data_rdy});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (ing.s_key_rdy !== 1'b1) begin
            n_fail++; $display("FAIL idle_rdy got %b want 1", ing.s_key_rdy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_first_pkt();
        logic [7:0] q[$];
        int t0;
        q = '{8'h47, 8'h45, 8'h54};
        run_pkt(32'hA, q, -1, -1, t0);
        exp_pkt++; exp_miss++;
        n_cmp++;
        if ({ld_sid, ld_new, ld_en} !== {6'd0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL first_id got sid=%0d new=%0b en=%0b want 0 1 1", ld_sid, ld_new, ld_en);
        end
        n_cmp++;
        if ({ld_cyc - t0, first_chr - t0, last_chr - t0, eop_cyc - t0} !== {32'd2, 32'd5, 32'd7, 32'd11}) begin
            n_fail++;
            $display("FAIL first_timing got ld=%0d c0=%0d cN=%0d eop=%0d want 2 5 7 11",
                     ld_cyc - t0, first_chr - t0, last_chr - t0, eop_cyc - t0);
        end
        n_cmp++;
        if ({eop_pkt, eop_miss} !== {16'(exp_pkt), 16'(exp_miss)}) begin
            n_fail++; $display("FAIL first_cnt got pkt=%0d miss=%0d want %0d %0d", eop_pkt, eop_miss, exp_pkt, exp_miss);
        end
    endtask

    task automatic test_hit();
        logic [7:0] q[$];
        int t0;
        q = '{8'h5A};
        run_pkt(32'hA, q, -1, -1, t0);
        exp_pkt++;
        n_cmp++;
        if ({ld_sid, ld_new} !== {6'd0, 1'b0}) begin
            n_fail++; $display("FAIL hit_id got sid=%0d new=%0b want 0 0", ld_sid, ld_new);
        end
        n_cmp++;
        if ({eop_pkt, eop_miss, 32'(eop_cyc - t0)} !== {16'(exp_pkt), 16'(exp_miss), 32'd9}) begin
            n_fail++;
            $display("FAIL hit_cnt got pkt=%0d miss=%0d eop=%0d want %0d %0d 9",
                     eop_pkt, eop_miss, eop_cyc - t0, exp_pkt, exp_miss);
        end
    endtask

    task automatic test_interleave();
        logic [7:0] q[$];
        logic [31:0] keys[3];
        logic [6:0]  want[3];
        int t0;
        keys = '{32'hB, 32'hA, 32'hB};
        want = '{{6'd1, 1'b1}, {6'd0, 1'b0}, {6'd1, 1'b0}};
        q = '{8'h31, 8'h32};
        for (int i = 0; i < 3; i++) begin
            run_pkt(keys[i], q, -1, -1, t0);
            exp_pkt++;
            if (want[i][0]) exp_miss++;
            n_cmp++;
            if ({ld_sid, ld_new} !== want[i]) begin
                n_fail++;
                $display("FAIL interleave_%0d got sid=%0d new=%0b want sid=%0d new=%0b",
                         i, ld_sid, ld_new, want[i][6:1], want[i][0]);
            end
        end
        n_cmp++;
        if ({eop_pkt, eop_miss} !== {16'(exp_pkt), 16'(exp_miss)}) begin
            n_fail++; $display("FAIL interleave_cnt got %0d %0d want %0d %0d", eop_pkt, eop_miss, exp_pkt, exp_miss);
        end
    endtask

    task automatic test_enable_cfg();
        logic [7:0] q[$];
        int t0;
        q = '{8'h61, 8'h62, 8'h63};
        run_pkt(32'hA, q, -1, 1, t0);   // cfg write lands while streaming byte 1
        exp_pkt++;
        n_cmp++;
        if (ld_en !== 1'b1) begin
            n_fail++; $display("FAIL en_inflight got %b want 1", ld_en);
        end
        q = '{8'h64};
        run_pkt(32'hA, q, -1, -1, t0);
        exp_pkt++;
        n_cmp++;
        if ({ld_sid, ld_en} !== {6'd0, 1'b0}) begin
            n_fail++; $display("FAIL en_next got sid=%0d en=%b want 0 0", ld_sid, ld_en);
        end
        cfg_en_we = 1'b1; cfg_en_addr = 6'd0; cfg_en_data = 1'b1;
        @(posedge clk); #1 cfg_en_we = 1'b0;
    endtask

    task automatic test_bubble();
        logic [7:0] q[$];
        int t0;
        q = '{8'h78, 8'h79, 8'h7A};
        run_pkt(32'hA, q, 0, -1, t0);
        exp_pkt++;
        n_cmp++;
        if (chr_cyc.size() != 3) begin
            n_fail++; $display("FAIL bubble_n got %0d chars want 3", chr_cyc.size());
        end else begin
            n_cmp++;
            if ({chr_cyc[0] - t0, chr_cyc[1] - t0, chr_cyc[2] - t0} !== {32'd5, 32'd7, 32'd8}) begin
                n_fail++;
                $display("FAIL bubble_gap got %0d %0d %0d want 5 7 8",
                         chr_cyc[0] - t0, chr_cyc[1] - t0, chr_cyc[2] - t0);
            end
        end
        n_cmp++;
        if ({eop_cyc - last_chr, eop_cyc - t0} !== {32'(DRAIN), 32'd12}) begin
            n_fail++; $display("FAIL bubble_drain got %0d %0d want %0d 12", eop_cyc - last_chr, eop_cyc - t0, DRAIN);
        end
        n_cmp++;
        if ({eop_pkt, ld_en} !== {16'(exp_pkt), 1'b1}) begin
            n_fail++; $display("FAIL bubble_cnt got pkt=%0d en=%b want %0d 1", eop_pkt, ld_en, exp_pkt);
        end
    endtask

    task automatic test_reset_midpkt();
        logic [7:0] q[$];
        int t0, n, e0;
        ing.s_key = 32'hC; ing.s_key_vld = 1'b1;
        for (n = 0; n < 50; n++) begin @(negedge clk); if (ing.s_key_rdy) break; end
        @(posedge clk); #1 ing.s_key_vld = 1'b0;
        repeat (4) @(posedge clk);   // now in STREAM with no byte offered
        #1 rst_n = 1'b0; e0 = n_eop;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({load_state, stream_id, new_stream_id, enable, char_in_vld, eop, pkt_count, miss_count,
             ing.s_key_rdy, ing.s_data_rdy} !== '0) begin
            n_fail++;
            $display("FAIL midrst_out got sid=%0d new=%b rdy=%b%b pkt=%0d miss=%0d want all 0",
                     stream_id, new_stream_id, ing.s_key_rdy, ing.s_data_rdy, pkt_count, miss_count);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        exp_chr_q = {}; exp_pkt = 0; exp_miss = 0;
        repeat (15) @(posedge clk);
        #1;
        n_cmp++;
        if (n_eop != e0) begin
            n_fail++; $display("FAIL midrst_eop got %0d eops want 0", n_eop - e0);
        end
        q = '{8'h41};
        run_pkt(32'hA, q, -1, -1, t0);
        exp_pkt++; exp_miss++;
        n_cmp++;
        if ({ld_sid, ld_new, eop_pkt, eop_miss} !== {6'd0, 1'b1, 16'(exp_pkt), 16'(exp_miss)}) begin
            n_fail++;
            $display("FAIL midrst_tbl got sid=%0d new=%b pkt=%0d miss=%0d want 0 1 %0d %0d",
                     ld_sid, ld_new, eop_pkt, eop_miss, exp_pkt, exp_miss);
        end
    endtask

    task automatic test_eviction();
        logic [7:0] q[$];
        int t0;
        logic [5:0] want_sid;
        do_reset();
        q = '{8'h55};
        for (int i = 0; i < 65; i++) begin
            run_pkt(32'h1000 + 32'(i), q, -1, -1, t0);
            exp_pkt++; exp_miss++;
            want_sid = 6'(i);
            n_cmp++;
            if ({ld_sid, ld_new} !== {want_sid, 1'b1}) begin
                n_fail++; $display("FAIL evict_fill_%0d got sid=%0d new=%b want %0d 1", i, ld_sid, ld_new, want_sid);
            end
        end
        // First key was evicted by key 64; it re-misses into slot 1.
        run_pkt(32'h1000, q, -1, -1, t0);
        exp_pkt++; exp_miss++;
        n_cmp++;
        if ({ld_sid, ld_new} !== {6'd1, 1'b1}) begin
            n_fail++; $display("FAIL evict_remiss got sid=%0d new=%b want 1 1", ld_sid, ld_new);
        end
        run_pkt(32'h1000 + 32'd64, q, -1, -1, t0);
        exp_pkt++;
        n_cmp++;
        if ({ld_sid, ld_new, eop_pkt, eop_miss} !== {6'd0, 1'b0, 16'(exp_pkt), 16'(exp_miss)}) begin
            n_fail++;
            $display("FAIL evict_hit got sid=%0d new=%b pkt=%0d miss=%0d want 0 0 %0d %0d",
                     ld_sid, ld_new, eop_pkt, eop_miss, exp_pkt, exp_miss);
        end
    endtask

    initial begin
        test_reset();
        test_first_pkt();
        test_hit();
        test_interleave();
        test_enable_cfg();
        test_bubble();
        test_reset_midpkt();
        test_eviction();
        n_cmp++;
        if (exp_chr_q.size() != 0) begin
            n_fail++; $display("FAIL chr_left got %0d pending want 0", exp_chr_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
